// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for a 5-stage pipeline (IF, ID, EX, MEM, WB).
// It drives the following signals from one place:
//   - the write enables of the PC and of the four pipeline registers,
//   - the IF/ID NOP-insert, the ID/EX valid gate and the MEM/WB bubble marker.
// It resolves load-use hazards, EX-stage redirects, I-cache and D-cache miss
// stalls, and halt.
//
// Each cycle falls into exactly one condition. The conditions are listed from
// highest priority to lowest:
//   RST > HALT > DMISS > FLUSH > LDUSE > IMISS > RUN
//
// Ports
//   clk           clock
//   rst           synchronous reset, active-high
//   id_rs/_used   ID-stage source register 1 and its "is read" flag
//   id_rt/_used   ID-stage source register 2 and its "is read" flag
//   ex_rd         EX-stage destination register
//   ex_regwrite   EX instruction writes a register
//   ex_memtoreg   EX instruction is a load
//   br_taken      EX-stage redirect (taken branch / jump)
//   imem_stall    instruction cache not ready
//   dmem_stall    data cache busy
//   halt_mem      halt instruction valid in MEM
//   pc_en         PC write enable
//   ifid_en       IF/ID enable
//   ifid_flush    IF/ID loads a NOP instead of the fetched word
//   idex_en       ID/EX enable
//   idex_valid    ID/EX valid gate (0 inserts a bubble)
//   exmem_en      EX/MEM enable
//   memwb_en      MEM/WB enable
//   memwb_bubble  MEM/WB input is a bubble
//   halted        sticky halt indicator
//   stall_cnt     saturating count of cycles with pc_en=0 while running
//   state         condition of the previous cycle (debug)
//
// The control outputs are combinational from the inputs, halted and rst.
// The signals halted, stall_cnt and state are registered.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic             id_rs_used,
    input  logic [2:0]       id_rt,
    input  logic             id_rt_used,
    input  logic [2:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic             br_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_valid,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             memwb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [2:0]       state
);

    // Encodings are visible on the debug "state" port, so they are fixed.
    typedef enum logic [2:0] {
        COND_RUN   = 3'd0,
        COND_LDUSE = 3'd1,
        COND_IMISS = 3'd2,
        COND_DMISS = 3'd3,
        COND_FLUSH = 3'd4,
        COND_HALT  = 3'd5
    } cond_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_halted;
    logic [CNT_W-1:0] r_stall_cnt;
    cond_e            r_state;

    logic             w_rs_hit;
    logic             w_rt_hit;
    logic             w_lduse;
    cond_e            w_cond;
    logic             w_stall_cycle;
    logic             w_set_halt;

    // -------------------------------------------------------------------------
    // Load-use detection.
    // The load's data only exists after MEM, so an ID consumer of the load's
    // destination must wait one cycle.
    // r0 gets no special treatment: a load to r0 still stalls the consumer.
    // -------------------------------------------------------------------------
    assign w_rs_hit = id_rs_used & (id_rs == ex_rd);
    assign w_rt_hit = id_rt_used & (id_rt == ex_rd);
    assign w_lduse  = ex_memtoreg & ex_regwrite & (w_rs_hit | w_rt_hit);

    // -------------------------------------------------------------------------
    // Condition priority.
    // RST is not part of this chain. It overrides every output directly below
    // and is never stored as a state value.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: a default on entry gives every path a value, so no latch is inferred.
        w_cond = COND_RUN;
        if (r_halted) begin
            w_cond = COND_HALT;
        end else if (dmem_stall) begin
            w_cond = COND_DMISS;
        end else if (br_taken) begin
            w_cond = COND_FLUSH;
        end else if (w_lduse) begin
            w_cond = COND_LDUSE;
        end else if (imem_stall) begin
            w_cond = COND_IMISS;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode. The default is the RUN pattern.
    // -------------------------------------------------------------------------
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_valid   = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        memwb_bubble = 1'b0;

        if (rst) begin
            // Everything advances with NOPs/bubbles, so the pipe drains clean.
            ifid_flush   = 1'b1;
            idex_valid   = 1'b0;
            memwb_bubble = 1'b1;
        end else begin
            unique case (w_cond)
                COND_HALT: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_en    = 1'b0;
                    idex_valid = 1'b0;
                    exmem_en   = 1'b0;
                    memwb_en   = 1'b0;
                end
                COND_DMISS: begin
                    // MEM is frozen. WB still clocks, but only a bubble, so
                    // the instruction already retired does not write twice.
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                end
                COND_FLUSH: begin
                    // Squash both wrong-path instructions (IF and ID).
                    // The PC loads the target.
                    ifid_flush = 1'b1;
                    idex_valid = 1'b0;
                end
                COND_LDUSE: begin
                    // Hold IF/ID and the PC, and push one bubble into EX.
                    // Next cycle EX holds that bubble, so the hazard clears.
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_valid = 1'b0;
                end
                COND_IMISS: begin
                    // Keep the PC pointing at the missing fetch. Feed NOPs
                    // into ID so that older instructions keep draining.
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
                default: begin
                    // COND_RUN: keep the defaults.
                end
            endcase
        end
    end

    // pc_en=0 while running counts as a stall cycle. Halt and reset cycles
    // are excluded.
    assign w_stall_cycle = ~rst & ~pc_en & (w_cond != COND_HALT);

    // A D-cache miss holds the halt in MEM, and the halt is re-presented later.
    // In any other cycle the halt instruction advances, and the halted state
    // takes effect behind it.
    assign w_set_halt = halt_mem & ~dmem_stall & ~rst;

    // -------------------------------------------------------------------------
    // Registered status.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here keep every register sampling pre-edge values.
        if (rst) begin
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
            r_state     <= COND_RUN;
        end else begin
            if (w_set_halt) begin
                r_halted <= 1'b1;
            end
            if (w_stall_cycle && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            r_state <= w_cond;
        end
    end

    assign halted    = r_halted;
    assign stall_cnt = r_stall_cnt;
    assign state     = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Two instances of pipe_hazard_ctrl share one stimulus:
//   - u_dut  uses the default CNT_W of 16,
//   - u_dut4 uses CNT_W = 4, so that counter saturation is reachable.
//
// The reference model works at the level of the condition rules:
//   - pick the winning condition,
//   - look up the required control pattern in a table,
//   - bump plain integer counters clamped to their maxima.
//
// Directed sequences with literal expectations come first. A long
// randomized run follows.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  id_rs, id_rt, ex_rd;
    logic        id_rs_used, id_rt_used, ex_regwrite, ex_memtoreg;
    logic        br_taken, imem_stall, dmem_stall, halt_mem;

    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_valid;
    logic        exmem_en, memwb_en, memwb_bubble, halted;
    logic [15:0] stall_cnt;
    logic [2:0]  state;

    logic        pc_en4, ifid_en4, ifid_flush4, idex_en4, idex_valid4;
    logic        exmem_en4, memwb_en4, memwb_bubble4, halted4;
    logic [3:0]  stall_cnt4;
    logic [2:0]  state4;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .br_taken(br_taken), .imem_stall(imem_stall), .dmem_stall(dmem_stall), .halt_mem(halt_mem),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_valid(idex_valid), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .memwb_bubble(memwb_bubble), .halted(halted), .stall_cnt(stall_cnt), .state(state)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .br_taken(br_taken), .imem_stall(imem_stall), .dmem_stall(dmem_stall), .halt_mem(halt_mem),
        .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4), .idex_en(idex_en4),
        .idex_valid(idex_valid4), .exmem_en(exmem_en4), .memwb_en(memwb_en4),
        .memwb_bubble(memwb_bubble4), .halted(halted4), .stall_cnt(stall_cnt4), .state(state4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    // Condition index: 0 RUN, 1 LDUSE, 2 IMISS, 3 DMISS, 4 FLUSH, 5 HALT, 6 RST.
    // Control vector bit order, MSB first:
    //   pc_en, ifid_en, ifid_flush, idex_en, idex_valid, exmem_en, memwb_en, memwb_bubble
    // Cleared care bits mark outputs whose value has no meaning in that
    // condition (for example, a NOP select on a register that is held).
    localparam logic [7:0] EXP_TAB [0:6] = '{
        8'b1101_1110,   // RUN
        8'b0001_0110,   // LDUSE
        8'b0111_1110,   // IMISS
        8'b0000_0011,   // DMISS
        8'b1111_0110,   // FLUSH
        8'b0000_0000,   // HALT
        8'b1111_0111    // RST
    };
    localparam logic [7:0] CARE_TAB [0:6] = '{
        8'hFF, 8'b1101_1111, 8'hFF, 8'b1101_0111, 8'hFF, 8'hFF, 8'hFF
    };

    bit m_known  = 1'b0;
    bit m_halted = 1'b0;
    int m_cnt16  = 0;
    int m_cnt4   = 0;
    int m_state  = 0;

    function automatic int model_cond();
        bit hazard;
        hazard = ex_memtoreg && ex_regwrite &&
                 ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
        if (rst)        return 6;
        if (m_halted)   return 5;
        if (dmem_stall) return 3;
        if (br_taken)   return 4;
        if (hazard)     return 1;
        if (imem_stall) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        int c;
        c = model_cond();
        if (rst) begin
            m_known  = 1'b1;
            m_halted = 1'b0;
            m_cnt16  = 0;
            m_cnt4   = 0;
            m_state  = 0;
        end else if (m_known) begin
            if (c == 1 || c == 2 || c == 3) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15)     m_cnt4++;
            end
            if (halt_mem && c != 3) m_halted = 1'b1;
            m_state = c;
        end
    end

    // The compare process runs on every falling edge once the model state is known.
    always @(negedge clk) begin
        if (m_known) begin
            int   c;
            logic [7:0] act;
            c   = model_cond();
            act = {pc_en, ifid_en, ifid_flush, idex_en, idex_valid, exmem_en, memwb_en, memwb_bubble};
            check($sformatf("ctrl_vec(cond%0d)", c), 32'(act & CARE_TAB[c]), 32'(EXP_TAB[c] & CARE_TAB[c]));
            check("halted", 32'(halted), 32'(m_halted));
            check("stall_cnt", 32'(stall_cnt), 32'(m_cnt16));
            check("stall_cnt4", 32'(stall_cnt4), 32'(m_cnt4));
            check("state", 32'(state), 32'(m_state));
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    task automatic idle();
        id_rs = 3'd0; id_rs_used = 1'b0; id_rt = 3'd0; id_rt_used = 1'b0;
        ex_rd = 3'd0; ex_regwrite = 1'b0; ex_memtoreg = 1'b0;
        br_taken = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0; halt_mem = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;

        // Reset cycle.
        @(negedge clk);
        check("rst_pc_en", 32'(pc_en), 32'd1);
        check("rst_ifid_flush", 32'(ifid_flush), 32'd1);
        check("rst_idex_valid", 32'(idex_valid), 32'd0);
        check("rst_memwb_bubble", 32'(memwb_bubble), 32'd1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_halted", 32'(halted), 32'd0);
        check("post_rst_cnt", 32'(stall_cnt), 32'd0);
        check("post_rst_state", 32'(state), 32'd0);
        check("run_idex_valid", 32'(idex_valid), 32'd1);

        // Load-use on rs.
        next_cycle();
        ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_used = 1'b1;
        @(negedge clk);
        check("lduse_pc_en", 32'(pc_en), 32'd0);
        check("lduse_ifid_en", 32'(ifid_en), 32'd0);
        check("lduse_idex_en", 32'(idex_en), 32'd1);
        check("lduse_idex_valid", 32'(idex_valid), 32'd0);
        next_cycle();
        ex_memtoreg = 1'b0;
        @(negedge clk);
        check("lduse_state", 32'(state), 32'd1);
        check("lduse_cnt", 32'(stall_cnt), 32'd1);
        check("lduse_release_pc_en", 32'(pc_en), 32'd1);

        // Matching registers whose "used" flags are clear: no hazard.
        next_cycle();
        ex_memtoreg = 1'b1; id_rs_used = 1'b0; id_rt = 3'd3; id_rt_used = 1'b0;
        @(negedge clk);
        check("unused_pc_en", 32'(pc_en), 32'd1);
        check("unused_ifid_en", 32'(ifid_en), 32'd1);
        check("unused_idex_valid", 32'(idex_valid), 32'd1);

        // A redirect beats an I-cache miss and a load-use match in the same cycle.
        next_cycle();
        id_rs_used = 1'b1; br_taken = 1'b1; imem_stall = 1'b1;
        @(negedge clk);
        check("flush_pc_en", 32'(pc_en), 32'd1);
        check("flush_ifid_en", 32'(ifid_en), 32'd1);
        check("flush_ifid_flush", 32'(ifid_flush), 32'd1);
        check("flush_idex_valid", 32'(idex_valid), 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        check("flush_state", 32'(state), 32'd4);
        check("flush_cnt", 32'(stall_cnt), 32'd1);

        // A D-cache miss held for 5 cycles with a pending redirect.
        next_cycle();
        dmem_stall = 1'b1; br_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            @(negedge clk);
            check("dmiss_pc_en", 32'(pc_en), 32'd0);
            check("dmiss_exmem_en", 32'(exmem_en), 32'd0);
            check("dmiss_memwb_en", 32'(memwb_en), 32'd1);
            check("dmiss_bubble", 32'(memwb_bubble), 32'd1);
        end
        next_cycle();
        dmem_stall = 1'b0;
        @(negedge clk);
        check("dmiss_state", 32'(state), 32'd3);
        check("dmiss_cnt", 32'(stall_cnt), 32'd6);
        check("dmiss_release_flush", 32'(ifid_flush), 32'd1);
        check("dmiss_release_pc_en", 32'(pc_en), 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check("dmiss_then_flush_state", 32'(state), 32'd4);

        // Halt: it becomes sticky and freezes the counter; reset clears it.
        next_cycle();
        halt_mem = 1'b1;
        @(negedge clk);
        check("halt_cycle_pc_en", 32'(pc_en), 32'd1);
        check("halt_cycle_halted", 32'(halted), 32'd0);
        next_cycle();
        halt_mem = 1'b0;
        @(negedge clk);
        check("halted_set", 32'(halted), 32'd1);
        check("halted_pc_en", 32'(pc_en), 32'd0);
        check("halted_memwb_en", 32'(memwb_en), 32'd0);
        check("halt_cycle_state", 32'(state), 32'd0);
        next_cycle();
        imem_stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("halted_cnt_frozen", 32'(stall_cnt), 32'd6);
            check("halted_state", 32'(state), 32'd5);
            next_cycle();
        end
        rst = 1'b1; imem_stall = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("unhalt_halted", 32'(halted), 32'd0);
        check("unhalt_cnt", 32'(stall_cnt), 32'd0);
        check("unhalt_state", 32'(state), 32'd0);

        // An I-cache miss held for 20 edges: the 4-bit counter saturates at 15.
        next_cycle();
        imem_stall = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        imem_stall = 1'b0;
        @(negedge clk);
        check("sat_cnt4", 32'(stall_cnt4), 32'd15);
        check("sat_cnt16", 32'(stall_cnt), 32'd20);
        check("imiss_state", 32'(state), 32'd2);

        // Randomized run. Small register indices make hazard matches frequent.
        for (int n = 0; n < 4000; n++) begin
            next_cycle();
            rst         = ($urandom_range(0, 79) == 0);
            halt_mem    = ($urandom_range(0, 39) == 0);
            dmem_stall  = ($urandom_range(0, 5) == 0);
            br_taken    = ($urandom_range(0, 4) == 0);
            imem_stall  = ($urandom_range(0, 3) == 0);
            ex_memtoreg = 1'($urandom_range(0, 1));
            ex_regwrite = ($urandom_range(0, 3) != 0);
            ex_rd       = 3'($urandom_range(0, 3));
            id_rs       = 3'($urandom_range(0, 3));
            id_rt       = 3'($urandom_range(0, 3));
            id_rs_used  = 1'($urandom_range(0, 1));
            id_rt_used  = 1'($urandom_range(0, 1));
        end
        next_cycle();
        idle();
        rst = 1'b0;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
